// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-issue fetch stage with a one-entry hold buffer and redirect support
module instruction_fetch_unit #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP_INSTR = N'(32'h00000013)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] instruction_out,
  output logic [N-1:0] pc_plus4_out,
  output logic         valid_out
);
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
  localparam logic [N-1:0] FOUR = N'(4);
  state_t r_state, w_state_nx;
  logic [N-1:0] r_pc, w_pc_nx, r_hold_pc, w_hold_pc_nx, r_hold_instr, w_hold_instr_nx;
  logic [N-1:0] r_pc_out, w_pc_out_nx, r_instr, w_instr_nx, r_pc4, w_pc4_nx;
  logic r_valid, w_valid_nx;
  logic [N-1:0] w_pc_plus4, w_hold_plus4;
  assign w_pc_plus4 = r_pc + FOUR;
  assign w_hold_plus4 = r_hold_pc + FOUR;
  assign imem_req = (r_state == FETCH) && !reset;
  assign imem_addr = r_pc;
  assign pc_out = r_pc_out;
  assign instruction_out = r_instr;
  assign pc_plus4_out = r_pc4;
  assign valid_out = r_valid;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    w_hold_pc_nx = r_hold_pc;
    w_hold_instr_nx = r_hold_instr;
    w_pc_out_nx = r_pc_out;
    w_instr_nx = r_instr;
    w_pc4_nx = r_pc4;
    w_valid_nx = r_valid;
    if (branch_taken) begin
      w_pc_nx = {branch_target[N-1:2], 2'b00};
      w_state_nx = FETCH;
      w_hold_pc_nx = '0;
      w_hold_instr_nx = '0;
      w_pc_out_nx = '0;
      w_instr_nx = NOP_INSTR;
      w_pc4_nx = '0;
      w_valid_nx = 1'b0;
    end else if (r_state == FETCH) begin
      if (imem_ready && !stall) begin
        w_pc_out_nx = r_pc;
        w_instr_nx = imem_rdata;
        w_pc4_nx = w_pc_plus4;
        w_valid_nx = 1'b1;
        w_pc_nx = w_pc_plus4;
      end else if (imem_ready) begin
        // downstream busy: park the completed fetch so it is not lost
        w_hold_pc_nx = r_pc;
        w_hold_instr_nx = imem_rdata;
        w_pc_nx = w_pc_plus4;
        w_state_nx = HOLD;
      end else if (!stall) begin
        w_pc_out_nx = '0;
        w_instr_nx = NOP_INSTR;
        w_pc4_nx = '0;
        w_valid_nx = 1'b0;
      end
    end else if (!stall) begin
      w_pc_out_nx = r_hold_pc;
      w_instr_nx = r_hold_instr;
      w_pc4_nx = w_hold_plus4;
      w_valid_nx = 1'b1;
      w_state_nx = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_hold_pc <= '0;
      r_hold_instr <= '0;
      r_pc_out <= '0;
      r_instr <= NOP_INSTR;
      r_pc4 <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_hold_pc <= w_hold_pc_nx;
      r_hold_instr <= w_hold_instr_nx;
      r_pc_out <= w_pc_out_nx;
      r_instr <= w_instr_nx;
      r_pc4 <= w_pc4_nx;
      r_valid <= w_valid_nx;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table, wrap and reset corners, then random traffic against a queue-level model
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;
  logic clk = 1'b0;
  logic reset, stall, branch_taken, imem_ready, imem_req, valid_out;
  logic [31:0] branch_target, imem_addr, imem_rdata, pc_out, instruction_out, pc_plus4_out, salt;
  logic reset2, stall2, branch_taken2, imem_ready2, imem_req2, valid_out2;
  logic [31:0] branch_target2, imem_addr2, imem_rdata2, pc_out2, instruction_out2, pc_plus4_out2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ salt;
  assign imem_rdata2 = imem_addr2 ^ KEY;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instruction_out(instruction_out), .pc_plus4_out(pc_plus4_out), .valid_out(valid_out));
  instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .branch_taken(branch_taken2),
    .branch_target(branch_target2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2), .pc_out(pc_out2),
    .instruction_out(instruction_out2), .pc_plus4_out(pc_plus4_out2), .valid_out(valid_out2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, stl, br;
    logic [31:0] tgt;
    logic rdy, e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(input logic rst, stl, br, input logic [31:0] tgt, input logic rdy, e_req,
                             input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
    vec_t t;
    t.rst = rst; t.stl = stl; t.br = br; t.tgt = tgt; t.rdy = rdy;
    t.e_req = e_req; t.e_addr = e_addr; t.e_valid = e_valid; t.e_pc = e_pc;
    return t;
  endfunction

  typedef struct {logic [31:0] pc, instr;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc, m_pcout, m_instr;
  logic m_valid;

  task automatic m_bubble();
    m_valid = 1'b0; m_pcout = '0; m_instr = NOP;
  endtask

  task automatic m_step(input logic rst, stl, br, rdy, input logic [31:0] tgt, input logic [31:0] s);
    ent_t f;
    logic fire;
    if (rst) begin
      m_pc = '0; q.delete(); m_bubble();
    end else if (br) begin
      m_pc = tgt & ~32'd3; q.delete(); m_bubble();
    end else begin
      fire = (q.size() == 0) && rdy;
      f.pc = m_pc; f.instr = m_pc ^ s;
      if (fire) m_pc = m_pc + 32'd4;
      if (!stl) begin
        if (q.size() != 0) begin
          f = q.pop_front();
          m_valid = 1'b1; m_pcout = f.pc; m_instr = f.instr;
        end else if (fire) begin
          m_valid = 1'b1; m_pcout = f.pc; m_instr = f.instr;
        end else m_bubble();
      end else if (fire) q.push_back(f);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b0; salt = KEY;
    reset2 = 1'b1; stall2 = 1'b0; branch_taken2 = 1'b0; branch_target2 = '0; imem_ready2 = 1'b0;
    //           rst   stl   br    tgt     rdy   req   addr    valid  pc
    tv.push_back(v(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h4));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h4));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h4));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h8));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'hC));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h10));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h10));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h10));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 1'b0, 32'h18,  1'b0, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 32'h100));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0));
    tv.push_back(v(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 32'h0));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0));
    foreach (tv[i]) begin
      reset = tv[i].rst; stall = tv[i].stl; branch_taken = tv[i].br;
      branch_target = tv[i].tgt; imem_ready = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tv[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_out}, {31'b0, tv[i].e_valid});
      chk($sformatf("vec%0d_pc", i), pc_out, tv[i].e_pc);
      chk($sformatf("vec%0d_pc4", i), pc_plus4_out, tv[i].e_valid ? tv[i].e_pc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d_instr", i), instruction_out, tv[i].e_valid ? tv[i].e_pc ^ KEY : NOP);
    end
    // wrap-around from the top of the address space
    reset2 = 1'b1; imem_ready2 = 1'b1;
    @(posedge clk); #1;
    reset2 = 1'b0;
    chk("wrap_addr0", imem_addr2, 32'hFFFFFFFC);
    @(posedge clk); #1;
    chk("wrap_pc0", pc_out2, 32'hFFFFFFFC);
    chk("wrap_pc4_0", pc_plus4_out2, 32'h0);
    chk("wrap_valid0", {31'b0, valid_out2}, 32'h1);
    chk("wrap_instr0", instruction_out2, 32'hFFFFFFFC ^ KEY);
    chk("wrap_addr1", imem_addr2, 32'h0);
    @(posedge clk); #1;
    chk("wrap_pc1", pc_out2, 32'h0);
    chk("wrap_pc4_1", pc_plus4_out2, 32'h4);
    // random traffic against the model
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    m_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, salt);
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 99) < 6);
      branch_target = $urandom;
      imem_ready = ($urandom_range(0, 9) < 7);
      salt = $urandom;
      #1;
      chk("rnd_req", {31'b0, imem_req}, {31'b0, !reset && q.size() == 0});
      if (imem_req) chk("rnd_addr", imem_addr, m_pc);
      m_step(reset, stall, branch_taken, imem_ready, branch_target, salt);
      @(posedge clk); #1;
      chk("rnd_valid", {31'b0, valid_out}, {31'b0, m_valid});
      chk("rnd_pc", pc_out, m_pcout);
      chk("rnd_instr", instruction_out, m_instr);
      chk("rnd_pc4", pc_plus4_out, m_valid ? m_pcout + 32'd4 : 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
